// File: rtl/lpc_host.sv
// lpc_host: LPC bus initiator. Runs one I/O or memory read/write cycle at a
// time from a command word whose fields match the decoder outputs
// (cyctype_dir, addr, data). Clocked directly by the LPC clock.
//
// Ports
//   clock, reset        LPC clock, synchronous active-high reset
//   in_cyctype_dir      [3:2] type (00 I/O, 01 mem), [1] write, [0] must be 0
//   in_addr, in_data    address (I/O uses [15:0]) and write data
//   in_valid/in_ready   command handshake; in_ready is high only when idle
//   lpc_ad_in           sampled LAD
//   lpc_ad_out/_oe      driven LAD and its output enable
//   lpc_frame           LFRAME#, active low
//   out_data            read data, held until replaced by a later read
//   out_status          00 ok, 01 sync error, 10 timeout, 11 unsupported
//   out_done            one-cycle completion pulse in the first idle cycle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus released, waiting for a command
// S_START   | LFRAME# low, START nibble 0000
// S_CYCTYPE | cycle type / direction nibble
// S_ADDR    | address nibbles, MSB first (4 for I/O, 8 for memory)
// S_WDATA   | write data, low nibble then high nibble
// S_TAR_H   | host turnaround: drive 1111, then release
// S_SYNC    | wait for target SYNC, count wait cycles
// S_RDATA   | capture read data, low nibble then high nibble
// S_TAR_P   | peripheral turnaround, bus released
// S_ABORT   | LFRAME# low with LAD 1111 for four cycles

module lpc_host #(
  parameter int unsigned SYNC_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  lpc_ad_in,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  output logic        lpc_frame,
  output logic [7:0]  out_data,
  output logic [1:0]  out_status,
  output logic        out_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_CYCTYPE,
    S_ADDR,
    S_WDATA,
    S_TAR_H,
    S_SYNC,
    S_RDATA,
    S_TAR_P,
    S_ABORT
  } state_t;

  localparam logic [3:0] LP_SYNC_READY = 4'b0000;
  localparam logic [3:0] LP_SYNC_ERROR = 4'b1010;
  localparam logic [3:0] LP_SYNC_LWAIT = 4'b0110;
  // Value of the wait counter on the last wait cycle that is tolerated.
  localparam logic [7:0] LP_WAIT_LAST  = 8'(SYNC_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cyc;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;
  logic [2:0]  r_cnt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nxt;
  logic [7:0]  r_data;
  logic [1:0]  r_status;
  logic        r_done;

  logic        w_accept;
  logic        w_unsup;
  logic        w_is_wr;
  logic [2:0]  w_nib_last;
  logic [2:0]  w_nib_idx;
  logic [3:0]  w_addr_nib;
  logic        w_sync_end;

  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_unsup    = in_cyctype_dir[3] | in_cyctype_dir[0];
  assign w_is_wr    = r_cyc[1];
  assign w_nib_last = r_cyc[2] ? 3'd7 : 3'd3;
  // r_cnt counts up from 0 in ADDR, so the nibble index walks MSB to LSB.
  assign w_nib_idx  = w_nib_last - r_cnt;
  assign w_addr_nib = r_addr[{w_nib_idx, 2'b00} +: 4];
  assign w_sync_end = (lpc_ad_in == LP_SYNC_READY) || (lpc_ad_in == LP_SYNC_ERROR);

  assign out_data   = r_data;
  assign out_status = r_status;
  assign out_done   = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = 8'd0;
    lpc_frame   = 1'b1;
    lpc_ad_oe   = 1'b0;
    lpc_ad_out  = 4'hF;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && !w_unsup) w_state_nxt = S_START;
      end
      S_START: begin
        lpc_frame   = 1'b0;
        lpc_ad_oe   = 1'b1;
        lpc_ad_out  = 4'h0;
        w_state_nxt = S_CYCTYPE;
      end
      S_CYCTYPE: begin
        lpc_ad_oe   = 1'b1;
        lpc_ad_out  = r_cyc;
        w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = w_addr_nib;
        if (r_cnt == w_nib_last) w_state_nxt = w_is_wr ? S_WDATA : S_TAR_H;
      end
      S_WDATA: begin
        lpc_ad_oe  = 1'b1;
        lpc_ad_out = r_cnt[0] ? r_wdata[7:4] : r_wdata[3:0];
        if (r_cnt[0]) w_state_nxt = S_TAR_H;
      end
      S_TAR_H: begin
        // Drive 1111 for one cycle before releasing so LAD never floats low.
        if (!r_cnt[0]) lpc_ad_oe = 1'b1;
        else           w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (w_sync_end) begin
          w_state_nxt = w_is_wr ? S_TAR_P : S_RDATA;
        end else if (lpc_ad_in == LP_SYNC_LWAIT) begin
          w_wait_nxt = 8'd0;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      S_RDATA: begin
        if (r_cnt[0]) w_state_nxt = S_TAR_P;
      end
      S_TAR_P: begin
        if (r_cnt[0]) w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        lpc_frame  = 1'b0;
        lpc_ad_oe  = 1'b1;
        if (r_cnt == 3'd3) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cyc    <= 4'h0;
      r_addr   <= 32'h0;
      r_wdata  <= 8'h0;
      r_cnt    <= 3'd0;
      r_wait   <= 8'd0;
      r_data   <= 8'h0;
      r_status <= 2'b00;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Per-state cycle counter: restarts on every state change.
      r_cnt   <= (w_state_nxt != r_state) ? 3'd0 : r_cnt + 3'd1;
      r_wait  <= w_wait_nxt;
      r_done  <= 1'b0;

      if (w_accept) begin
        r_cyc    <= in_cyctype_dir;
        r_addr   <= in_addr;
        r_wdata  <= in_data;
        // Unsupported commands complete on the very next cycle without bus activity.
        r_status <= w_unsup ? 2'b11 : 2'b00;
        r_done   <= w_unsup;
      end

      case (r_state)
        S_SYNC: begin
          if (lpc_ad_in == LP_SYNC_ERROR) r_status <= 2'b01;
        end
        S_RDATA: begin
          if (r_cnt[0]) r_data[7:4] <= lpc_ad_in;
          else          r_data[3:0] <= lpc_ad_in;
        end
        S_TAR_P: begin
          if (r_cnt[0]) r_done <= 1'b1;
        end
        S_ABORT: begin
          if (r_cnt == 3'd3) begin
            r_done   <= 1'b1;
            r_status <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
